minterm_lut: RTL and testbench

MINTERM_LUT -- requirements
Module: minterm_lut

---
 rtl/minterm_lut.sv | 105 ++++++++++
 tb/tb_minterm_lut.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/minterm_lut.sv
// Loadable N-input truth table with single-cycle evaluation and a scan FSM that lists the true minterms.
// Define MINTERM_LUT_COUNT_EN to make ones_count track popcount(table); otherwise ones_count is 0.
module minterm_lut #(
  parameter int N = 5,
  parameter logic [(1<<N)-1:0] INIT = 32'h7F304C3F
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  input  logic         load_bit,
  input  logic         in_valid,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  output logic         f,
  input  logic         scan_start,
  output logic         scan_busy,
  output logic         scan_valid,
  output logic [N-1:0] scan_idx,
  output logic         scan_done,
  output logic [N:0]   ones_count
);
  localparam int DEPTH = 1 << N;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DEPTH-1:0] tbl;
  logic [N-1:0]     idx;
  logic             idx_last, hit, done_nxt;

  assign idx_last  = &idx;
  assign scan_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_start) state_nxt = SCAN;
      SCAN:    if (idx_last)   state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hit      = (state == SCAN) && tbl[idx];
    done_nxt = (state == DONE);
  end

  // Index stops at the last minterm; it is re-armed only by a fresh start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          idx <= '0;
    else if (state == IDLE && scan_start)  idx <= '0;
    else if (state == SCAN && !idx_last)   idx <= idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_valid <= 1'b0;
      scan_idx   <= '0;
      scan_done  <= 1'b0;
    end else begin
      scan_valid <= hit;
      scan_done  <= done_nxt;
      if (hit) scan_idx <= idx;
    end
  end

  // Table is frozen while the scan owns it so the reported list stays coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    tbl <= INIT;
    else if (load_en && !scan_busy)  tbl <= {load_bit, tbl[DEPTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      f         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) f <= tbl[in_vec];
    end
  end

`ifdef MINTERM_LUT_COUNT_EN
  function automatic logic [N:0] popcount(input logic [DEPTH-1:0] v);
    logic [N:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (N+1)'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ones_count <= popcount(INIT);
    else          ones_count <= popcount(tbl);
  end
`else
  assign ones_count = '0;
`endif

endmodule

// File: tb/tb_minterm_lut.sv
// Directed bench for minterm_lut: evaluation, scan enumeration, loading, reset abort, read-before-write.
module tb_minterm_lut;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_en = 1'b0, load_bit = 1'b0, in_valid = 1'b0, scan_start = 1'b0;
  logic [4:0] in_vec = '0;
  logic       out_valid, f, scan_busy, scan_valid, scan_done;
  logic [4:0] scan_idx;
  logic [5:0] ones_count;

  logic       load_en3 = 1'b0, load_bit3 = 1'b0, in_valid3 = 1'b0, scan_start3 = 1'b0;
  logic [2:0] in_vec3 = '0;
  logic       out_valid3, f3, scan_busy3, scan_valid3, scan_done3;
  logic [2:0] scan_idx3;
  logic [3:0] ones_count3;

  int n_chk = 0;
  int n_err = 0;

`ifdef MINTERM_LUT_COUNT_EN
  localparam int ONES_INIT = 18, ONES_LOADED = 2;
`else
  localparam int ONES_INIT = 0, ONES_LOADED = 0;
`endif
  localparam logic [31:0] INIT_MASK = 32'h7F304C3F;

  always #5 clk = ~clk;

  minterm_lut dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_bit(load_bit),
    .in_valid(in_valid), .in_vec(in_vec), .out_valid(out_valid), .f(f),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
    .scan_idx(scan_idx), .scan_done(scan_done), .ones_count(ones_count)
  );

  minterm_lut #(.N(3), .INIT(8'hA5)) dut3 (
    .clk(clk), .reset_n(reset_n), .load_en(load_en3), .load_bit(load_bit3),
    .in_valid(in_valid3), .in_vec(in_vec3), .out_valid(out_valid3), .f(f3),
    .scan_start(scan_start3), .scan_busy(scan_busy3), .scan_valid(scan_valid3),
    .scan_idx(scan_idx3), .scan_done(scan_done3), .ones_count(ones_count3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval(input logic [4:0] v, input logic exp);
    in_valid = 1'b1; in_vec = v;
    tick();
    chk($sformatf("out_valid(%0d)", v), {31'b0, out_valid}, 32'd1);
    chk($sformatf("f(%0d)", v), {31'b0, f}, {31'b0, exp});
    in_valid = 1'b0;
  endtask

  // Start a scan, optionally hold load_en and re-pulse scan_start mid-scan; return found mask and latency.
  task automatic run_scan(input logic hold_load, input int restart_at,
                          output logic [31:0] mask, output int hits, output int lat);
    logic [4:0] last;
    mask = '0; hits = 0; lat = -1; last = '0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("busy_after_start", {31'b0, scan_busy}, 32'd1);
    for (int c = 1; c <= 60; c++) begin
      load_en = hold_load; load_bit = 1'b0;
      scan_start = (c == restart_at);
      tick();
      if (scan_valid) begin
        mask[scan_idx] = 1'b1; hits++; last = scan_idx;
      end else if (c == 8) begin
        chk("idx_hold", {27'b0, scan_idx}, {27'b0, last});
      end
      if (scan_done) begin lat = c; break; end
    end
    load_en = 1'b0; scan_start = 1'b0;
    if (lat < 0) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] mask, ld;
    int hits, lat, dn;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mask, ld;
    int hits, lat, dn;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_f", {31'b0, f}, 32'd0);
    chk("rst_busy", {31'b0, scan_busy}, 32'd0);
    chk("rst_scan_valid", {31'b0, scan_valid}, 32'd0);
    chk("rst_scan_done", {31'b0, scan_done}, 32'd0);
    chk("rst_scan_idx", {27'b0, scan_idx}, 32'd0);
    chk("rst_ones", {26'b0, ones_count}, ONES_INIT);
    #10 reset_n = 1'b1;
    tick();

    eval(5'd0, 1'b1);
    eval(5'd6, 1'b0);
    eval(5'd14, 1'b1);
    eval(5'd31, 1'b0);
    tick();
    chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("f_hold", {31'b0, f}, 32'd0);

    run_scan(1'b0, 0, mask, hits, lat);
    chk("scan_mask", mask, INIT_MASK);
    chk("scan_hits", hits, 32'd18);
    chk("scan_latency", lat, 32'd33);
    chk("ones_init", {26'b0, ones_count}, ONES_INIT);
    tick();
    chk("busy_after_done", {31'b0, scan_busy}, 32'd0);
    chk("done_one_cycle", {31'b0, scan_done}, 32'd0);

    run_scan(1'b1, 5, mask, hits, lat);
    chk("hold_load_mask", mask, INIT_MASK);
    chk("restart_ignored_lat", lat, 32'd33);
    run_scan(1'b0, 0, mask, hits, lat);
    chk("rescan_mask", mask, INIT_MASK);
    chk("rescan_latency", lat, 32'd33);

    // Reset while the scan is testing index 9.
    in_valid = 1'b1; in_vec = 5'd0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("pre_rst_busy", {31'b0, scan_busy}, 32'd1);
    chk("pre_rst_f", {31'b0, f}, 32'd1);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, scan_busy}, 32'd0);
    chk("abort_scan_valid", {31'b0, scan_valid}, 32'd0);
    chk("abort_scan_idx", {27'b0, scan_idx}, 32'd0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_f", {31'b0, f}, 32'd0);
    #2 reset_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (scan_done) dn++;
    end
    chk("abort_no_done", dn, 32'd0);
    run_scan(1'b0, 0, mask, hits, lat);
    chk("post_rst_mask", mask, INIT_MASK);

    ld = 32'h80000001;
    for (int i = 0; i < 32; i++) begin
      load_en = 1'b1; load_bit = ld[i];
      tick();
    end
    load_en = 1'b0;
    tick();
    chk("ones_loaded", {26'b0, ones_count}, ONES_LOADED);
    eval(5'd0, 1'b1);
    eval(5'd31, 1'b1);
    eval(5'd5, 1'b0);

    in_valid3 = 1'b1; in_vec3 = 3'd2; load_en3 = 1'b1; load_bit3 = 1'b0;
    tick();
    load_en3 = 1'b0;
    chk("rbw_valid3", {31'b0, out_valid3}, 32'd1);
    chk("rbw_f3", {31'b0, f3}, 32'd1);
    tick();
    chk("after_load_f3", {31'b0, f3}, 32'd0);
    in_valid3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
